ysyx_23060184_pc_unit: RTL and testbench
========================================

# ysyx_23060184_pc_unit

Sequential program-counter unit for the multi-cycle core. It holds the architectural PC and offers it to the IFU through a valid/ready handshake. It then waits for the EXU to hand back the resolved control-flow decision and computes and registers the next PC. Beyond plain next-PC selection, it adds conditional branch resolution, trap/return redirection, target-misalignment detection, a retire counter and width/reset-vector parametrisation. It sits between the EXU/CSR file and the IFU.

## Interface
- DATA_WIDTH, 32, PC/data width; must be ≥ 32.
- NPC_OP_LENGTH, 3, width of the next-PC opcode.
- RESET_PC, 32'h8000_0000 (zero-extended to DATA_WIDTH), PC loaded by reset.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_valid  out  1  the PC on `pc` is offered to the IFU.
- pc_ready  in  1  IFU accepts `pc`.
- pc  out  DATA_WIDTH  current PC.
- exu_ready  out  1  unit waits for the control-flow result.
- exu_valid  in  1  EXU result valid.
- npc_op  in  NPC_OP_LENGTH  0 NEXT, 1 JAL, 2 JALR, 3 BRANCH, 4 TRAP, 5 MRET, others NEXT.
- inst  in  32  current instruction (immediate source).
- alu_result  in  DATA_WIDTH  JALR raw target.
- br_taken  in  1  branch condition result (BRANCH only).
- mtvec  in  DATA_WIDTH  trap vector.
- mepc  in  DATA_WIDTH  return address.
- misalign  out  1  one-cycle pulse: misaligned target detected.
- retire_cnt  out  DATA_WIDTH  count of completed EXU handshakes.

## Operation
- States: S_RESET, S_FETCH, S_EXEC.
- `pc_valid` = (state == S_FETCH).
- `exu_ready` = (state == S_EXEC).
- Transitions:
  - S_RESET → S_FETCH on the first clock after `rst` deasserts.
  - S_FETCH → S_EXEC when pc_valid && pc_ready.
  - S_EXEC → S_FETCH when exu_valid && exu_ready.
- Inputs npc_op, inst, alu_result, br_taken, mtvec and mepc are sampled only on the EXU handshake cycle.
- Target computation (all sums modulo 2^DATA_WIDTH; immediates sign-extended to DATA_WIDTH):
  - NEXT: pc + 4.
  - JAL: pc + {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - JALR: alu_result with bit 0 forced to 0.
  - BRANCH: if br_taken, pc + {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; otherwise pc + 4.
  - TRAP: mtvec with bits [1:0] forced to 0.
  - MRET: mepc.
- Misalignment: applies to JAL, JALR and taken BRANCH only. If target bit 1 is set, the unit loads mtvec (bits [1:0] forced to 0) instead of the target and pulses `misalign` in the same cycle as the PC update. No other ops check alignment.
- `retire_cnt` increments by 1 on every EXU handshake and wraps from all-ones to 0.
- Reset (asynchronous, any state, including mid-handshake):
  - pc = RESET_PC, state = S_RESET, retire_cnt = 0, misalign = 0.
  - pc_valid = 0, exu_ready = 0.
  - An in-flight fetch or EXU result is discarded.

## Timing
- Reset values: pc = RESET_PC; pc_valid, exu_ready, misalign, retire_cnt = 0.
- `pc_valid` rises one cycle after `rst` falls and holds until accepted. `pc` is stable while `pc_valid` is high.
- IFU accept at edge N: `exu_ready` = 1 from cycle N+1.
- EXU handshake at edge M:
  - new `pc`, updated `retire_cnt` and any `misalign` pulse are visible from cycle M+1.
  - `pc_valid` = 1 in cycle M+1.
- Minimum loop: 2 cycles per instruction (both handshakes immediate).
- `exu_valid` asserted outside S_EXEC is ignored.
- `pc_ready` asserted outside S_FETCH is ignored.
- No combinational path from input to output except state-decoded valid/ready.

## Test plan
- Reset / sequential: hold rst 3 cycles, release; IFU and EXU always ready, npc_op = NEXT → pc sequence 8000_0000, 8000_0004, 8000_0008 at 2-cycle spacing; retire_cnt 0, 1, 2.
- JAL / JALR: pc = 8000_0010, inst = 0x0080_006F (JAL +8) → pc = 8000_0018. Then JALR with alu_result = 8000_0101 → pc = 8000_0100, misalign = 0.
- Branch: BRANCH with offset −16 from 8000_0040. br_taken = 1 → 8000_0030; br_taken = 0 → 8000_0044.
- Trap / return / misalign:
  - TRAP, mtvec = 8000_1003 → pc = 8000_1000.
  - MRET, mepc = 8000_0200 → pc = 8000_0200.
  - JALR with alu_result = 8000_0006, mtvec = 8000_1000 → pc = 8000_1000 and a single-cycle misalign pulse.
- Backpressure / reset mid-op: hold pc_ready = 0 for 5 cycles → pc_valid stays 1 and pc is unchanged. Assert rst while in S_EXEC with exu_valid = 1 → pc = RESET_PC, retire_cnt = 0, result dropped.
- Wrap-around: pc = FFFF_FFFC with NEXT → pc = 0000_0000; retire_cnt preset via long run to FFFF_FFFF → increments to 0.

Source files
------------

// File: rtl/ysyx_23060184_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060184_pc_unit
// Description : Program-counter unit for the multi-cycle core. Offers the
//               current PC to the IFU, waits for the EXU control-flow
//               result, then registers the next PC. It handles branches,
//               traps, MRET, misaligned-target redirection and a retire
//               counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060184_pc_unit #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    NPC_OP_LENGTH = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = DATA_WIDTH'(32'h8000_0000)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     pc_valid,
  input  logic                     pc_ready,
  output logic [DATA_WIDTH-1:0]    pc,
  output logic                     exu_ready,
  input  logic                     exu_valid,
  input  logic [NPC_OP_LENGTH-1:0] npc_op,
  input  logic [31:0]              inst,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic                     br_taken,
  input  logic [DATA_WIDTH-1:0]    mtvec,
  input  logic [DATA_WIDTH-1:0]    mepc,
  output logic                     misalign,
  output logic [DATA_WIDTH-1:0]    retire_cnt
);

  // Next-PC opcode encodings
  localparam logic [NPC_OP_LENGTH-1:0] c_op_jal    = NPC_OP_LENGTH'(1);
  localparam logic [NPC_OP_LENGTH-1:0] c_op_jalr   = NPC_OP_LENGTH'(2);
  localparam logic [NPC_OP_LENGTH-1:0] c_op_branch = NPC_OP_LENGTH'(3);
  localparam logic [NPC_OP_LENGTH-1:0] c_op_trap   = NPC_OP_LENGTH'(4);
  localparam logic [NPC_OP_LENGTH-1:0] c_op_mret   = NPC_OP_LENGTH'(5);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   retire_cnt_q, retire_cnt_d;
  logic                    misalign_q, misalign_d;

  logic [DATA_WIDTH-1:0]   imm_j;
  logic [DATA_WIDTH-1:0]   imm_b;
  logic [DATA_WIDTH-1:0]   pc_plus4;
  logic [DATA_WIDTH-1:0]   trap_vec;
  logic [DATA_WIDTH-1:0]   target;
  logic                    check_align;
  logic                    misalign_hit;
  logic [DATA_WIDTH-1:0]   next_pc;

  // Instruction bits that carry no immediate information, the JALR LSB and
  // the mtvec mode bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{inst[6:0], alu_result[0], mtvec[1:0]};

  // J-type and B-type immediates, sign-extended to the PC width
  assign imm_j = {{(DATA_WIDTH-21){inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};
  assign imm_b = {{(DATA_WIDTH-13){inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);
  assign trap_vec = {mtvec[DATA_WIDTH-1:2], 2'b00};

  // Raw target selection; only jumps and taken branches are alignment-checked
  always_comb begin
    target      = pc_plus4;
    check_align = 1'b0;
    case (npc_op)
      c_op_jal: begin
        target      = pc_q + imm_j;
        check_align = 1'b1;
      end
      c_op_jalr: begin
        target      = {alu_result[DATA_WIDTH-1:1], 1'b0};
        check_align = 1'b1;
      end
      c_op_branch: begin
        if (br_taken) begin
          target      = pc_q + imm_b;
          check_align = 1'b1;
        end
      end
      c_op_trap: target = trap_vec;
      c_op_mret: target = mepc;
      default:   target = pc_plus4;
    endcase
  end

  // A misaligned target redirects to the trap vector instead
  assign misalign_hit = check_align & target[1];
  assign next_pc      = misalign_hit ? trap_vec : target;

  // Next-state and datapath update; misalign defaults low so it only pulses
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    retire_cnt_d = retire_cnt_q;
    misalign_d   = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (pc_ready) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exu_valid) begin
          state_d      = S_FETCH;
          pc_d         = next_pc;
          retire_cnt_d = retire_cnt_q + DATA_WIDTH'(1);
          misalign_d   = misalign_hit;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  // State and architectural registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RESET;
      pc_q         <= RESET_PC;
      retire_cnt_q <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      retire_cnt_q <= retire_cnt_d;
      misalign_q   <= misalign_d;
    end
  end

  assign pc_valid   = (state_q == S_FETCH);
  assign exu_ready  = (state_q == S_EXEC);
  assign pc         = pc_q;
  assign retire_cnt = retire_cnt_q;
  assign misalign   = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060184_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060184_pc_unit
// Description : Directed self-checking bench for the PC unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060184_pc_unit;

  localparam int DW = 32;

  localparam logic [2:0] OP_NEXT   = 3'd0;
  localparam logic [2:0] OP_JAL    = 3'd1;
  localparam logic [2:0] OP_JALR   = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_TRAP   = 3'd4;
  localparam logic [2:0] OP_MRET   = 3'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          pc_valid;
  logic          pc_ready;
  logic [DW-1:0] pc;
  logic          exu_ready;
  logic          exu_valid;
  logic [2:0]    npc_op;
  logic [31:0]   inst;
  logic [DW-1:0] alu_result;
  logic          br_taken;
  logic [DW-1:0] mtvec;
  logic [DW-1:0] mepc;
  logic          misalign;
  logic [DW-1:0] retire_cnt;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_retire;

  ysyx_23060184_pc_unit #(
    .DATA_WIDTH    (DW),
    .NPC_OP_LENGTH (3),
    .RESET_PC      (32'h8000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .pc         (pc),
    .exu_ready  (exu_ready),
    .exu_valid  (exu_valid),
    .npc_op     (npc_op),
    .inst       (inst),
    .alu_result (alu_result),
    .br_taken   (br_taken),
    .mtvec      (mtvec),
    .mepc       (mepc),
    .misalign   (misalign),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one instruction from S_FETCH: IFU accept, then EXU handshake.
  // Returns at a falling edge with the unit back in S_FETCH.
  task automatic do_insn(input string tag, input logic [2:0] op, input logic [31:0] ins,
                         input logic [DW-1:0] alu, input logic br,
                         input logic [DW-1:0] tvec, input logic [DW-1:0] epc,
                         input logic [DW-1:0] exp_pc, input logic exp_mis);
    chk({tag, ".pc_valid"}, 64'(pc_valid), 64'd1);
    pc_ready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    chk({tag, ".exu_ready"}, 64'(exu_ready), 64'd1);
    npc_op     = op;
    inst       = ins;
    alu_result = alu;
    br_taken   = br;
    mtvec      = tvec;
    mepc       = epc;
    exu_valid  = 1'b1;
    @(negedge clk);
    exu_valid  = 1'b0;
    npc_op     = OP_NEXT;
    exp_retire = exp_retire + 32'd1;
    chk({tag, ".pc"}, 64'(pc), 64'(exp_pc));
    chk({tag, ".misalign"}, 64'(misalign), 64'(exp_mis));
    chk({tag, ".retire"}, 64'(retire_cnt), 64'(exp_retire));
    chk({tag, ".pc_valid_after"}, 64'(pc_valid), 64'd1);
    @(negedge clk);
    chk({tag, ".misalign_clear"}, 64'(misalign), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    pc_ready   = 1'b0;
    exu_valid  = 1'b0;
    npc_op     = OP_NEXT;
    inst       = 32'h0000_0013;
    alu_result = '0;
    br_taken   = 1'b0;
    mtvec      = '0;
    mepc       = '0;
    exp_retire = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.pc", 64'(pc), 64'h8000_0000);
    chk("rst.pc_valid", 64'(pc_valid), 64'd0);
    chk("rst.exu_ready", 64'(exu_ready), 64'd0);
    chk("rst.misalign", 64'(misalign), 64'd0);
    chk("rst.retire", 64'(retire_cnt), 64'd0);

    // Sequential NEXT with IFU and EXU always ready
    rst       = 1'b0;
    pc_ready  = 1'b1;
    exu_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("seq.pc_valid", 64'(pc_valid), 64'd1);
      chk("seq.pc", 64'(pc), 64'(32'h8000_0000 + 32'(4 * i)));
      chk("seq.retire", 64'(retire_cnt), 64'(i));
      if (i < 2) begin
        @(negedge clk);
        chk("seq.exu_ready", 64'(exu_ready), 64'd1);
        @(negedge clk);
      end
    end
    pc_ready   = 1'b0;
    exu_valid  = 1'b0;
    exp_retire = 32'd2;

    // Backpressure: pc held, stray exu_valid ignored
    for (int i = 0; i < 5; i++) begin
      exu_valid = (i == 2);
      @(negedge clk);
      chk("bp.pc_valid", 64'(pc_valid), 64'd1);
      chk("bp.pc", 64'(pc), 64'h8000_0008);
    end
    exu_valid = 1'b0;
    chk("bp.retire", 64'(retire_cnt), 64'd2);

    do_insn("next0", OP_NEXT, 32'h13, '0, 1'b0, '0, '0, 32'h8000_000C, 1'b0);
    do_insn("next1", OP_NEXT, 32'h13, '0, 1'b0, '0, '0, 32'h8000_0010, 1'b0);

    // JAL / JALR
    do_insn("jal", OP_JAL, 32'h0080_006F, '0, 1'b0, '0, '0, 32'h8000_0018, 1'b0);
    do_insn("jalr", OP_JALR, 32'h0000_0067, 32'h8000_0101, 1'b0, '0, '0, 32'h8000_0100, 1'b0);

    // Branch, offset -16 from 8000_0040
    do_insn("mret40a", OP_MRET, 32'h0, '0, 1'b0, '0, 32'h8000_0040, 32'h8000_0040, 1'b0);
    do_insn("br_taken", OP_BRANCH, 32'hFE00_08E3, '0, 1'b1, '0, '0, 32'h8000_0030, 1'b0);
    do_insn("mret40b", OP_MRET, 32'h0, '0, 1'b0, '0, 32'h8000_0040, 32'h8000_0040, 1'b0);
    do_insn("br_not", OP_BRANCH, 32'hFE00_08E3, '0, 1'b0, '0, '0, 32'h8000_0044, 1'b0);

    // Trap, return, misalignment
    do_insn("trap", OP_TRAP, 32'h0, '0, 1'b0, 32'h8000_1003, '0, 32'h8000_1000, 1'b0);
    do_insn("mret", OP_MRET, 32'h0, '0, 1'b0, '0, 32'h8000_0200, 32'h8000_0200, 1'b0);
    do_insn("jalr_mis", OP_JALR, 32'h0, 32'h8000_0006, 1'b0, 32'h8000_1000, '0, 32'h8000_1000, 1'b1);
    do_insn("br_mis", OP_BRANCH, 32'h0000_0163, '0, 1'b1, 32'h8000_2001, '0, 32'h8000_2000, 1'b1);
    do_insn("br_nt_noch", OP_BRANCH, 32'h0000_0163, '0, 1'b0, 32'h8000_3000, '0, 32'h8000_2004, 1'b0);
    do_insn("trap_nochk", OP_TRAP, 32'h0, '0, 1'b0, 32'h0000_0002, '0, 32'h0000_0000, 1'b0);

    // PC wrap-around
    do_insn("mret_top", OP_MRET, 32'h0, '0, 1'b0, '0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    do_insn("wrap", OP_NEXT, 32'h13, '0, 1'b0, '0, '0, 32'h0000_0000, 1'b0);

    // Reset while an EXU result is being presented
    pc_ready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    chk("midrst.exu_ready", 64'(exu_ready), 64'd1);
    npc_op    = OP_JAL;
    inst      = 32'h0080_006F;
    exu_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst.pc_async", 64'(pc), 64'h8000_0000);
    @(negedge clk);
    chk("midrst.pc", 64'(pc), 64'h8000_0000);
    chk("midrst.retire", 64'(retire_cnt), 64'd0);
    chk("midrst.exu_ready", 64'(exu_ready), 64'd0);
    chk("midrst.pc_valid", 64'(pc_valid), 64'd0);
    exu_valid = 1'b0;
    npc_op    = OP_NEXT;
    rst       = 1'b0;
    @(negedge clk);
    chk("post.pc_valid", 64'(pc_valid), 64'd1);
    chk("post.pc", 64'(pc), 64'h8000_0000);
    exp_retire = '0;
    do_insn("post_next", OP_NEXT, 32'h13, '0, 1'b0, '0, '0, 32'h8000_0004, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
